// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Zero-latency IF lookup, EX-stage training, mispredict/redirect and perf counters.
module branch_predictor_btb #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned STAT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   if_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_is_jump,
  input  logic              upd_pred_taken,
  input  logic [XLEN-1:0]   upd_pred_target,
  input  logic              inv_all,
  output logic              mispredict,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  // Counter encodings derived without zero-width replications so CNT_W = 1 works.
  localparam logic [CNT_W-1:0] CtrMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CtrWnt = CtrMax >> 1;
  localparam logic [CNT_W-1:0] CtrWt  = CtrMax ^ (CtrMax >> 1);
  localparam logic [CNT_W-1:0] CtrOne = CNT_W'(1);

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [XLEN-1:0]  target_d [ENTRIES];
  logic [CNT_W-1:0] ctr_q    [ENTRIES];
  logic [CNT_W-1:0] ctr_d    [ENTRIES];
  logic             jump_q   [ENTRIES];
  logic             jump_d   [ENTRIES];

  logic [STAT_W-1:0] stat_updates_q, stat_updates_d;
  logic [STAT_W-1:0] stat_mispred_q, stat_mispred_d;

  logic [IDX_W-1:0] if_idx, upd_idx;
  logic [TAG_W-1:0] if_tag, upd_tag;
  logic             upd_hit;

  assign if_idx  = if_pc[IDX_W+1:2];
  assign if_tag  = if_pc[XLEN-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[XLEN-1:IDX_W+2];

  always_comb begin
    pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = pred_hit && (jump_q[if_idx] || ctr_q[if_idx][CNT_W-1]);
    pred_target = pred_taken ? target_q[if_idx] : if_pc + XLEN'(4);
  end

  always_comb begin
    mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                (upd_taken && (upd_target != upd_pred_target)));
    redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);
  end

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    jump_d   = jump_q;
    if (inv_all) begin
      // Invalidation wins over any same-cycle training.
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_d[i] = 1'b0;
        ctr_d[i]   = CtrWnt;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          target_d[upd_idx] = upd_target;
          jump_d[upd_idx]   = upd_is_jump;
          if (upd_is_jump || (ctr_q[upd_idx] == CtrMax)) begin
            ctr_d[upd_idx] = CtrMax;
          end else begin
            ctr_d[upd_idx] = ctr_q[upd_idx] + CtrOne;
          end
        end else if (ctr_q[upd_idx] != '0) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - CtrOne;
        end
      end else if (upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        jump_d[upd_idx]   = upd_is_jump;
        ctr_d[upd_idx]    = upd_is_jump ? CtrMax : CtrWt;
      end
    end
  end

  always_comb begin
    stat_updates_d = stat_updates_q;
    stat_mispred_d = stat_mispred_q;
    if (upd_valid && (stat_updates_q != {STAT_W{1'b1}})) begin
      stat_updates_d = stat_updates_q + STAT_W'(1);
    end
    if (mispredict && (stat_mispred_q != {STAT_W{1'b1}})) begin
      stat_mispred_d = stat_mispred_q + STAT_W'(1);
    end
  end

  assign stat_updates = stat_updates_q;
  assign stat_mispred = stat_mispred_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CtrWnt;
        jump_q[i]   <= 1'b0;
      end
      stat_updates_q <= '0;
      stat_mispred_q <= '0;
    end else begin
      valid_q        <= valid_d;
      tag_q          <= tag_d;
      target_q       <= target_d;
      ctr_q          <= ctr_d;
      jump_q         <= jump_d;
      stat_updates_q <= stat_updates_d;
      stat_mispred_q <= stat_mispred_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: directed scenario steps followed by random traffic,
// all checked against a table-of-records reference model.
module tb_branch_predictor_btb;

  localparam int unsigned ENT = 16;
  localparam int unsigned CW  = 2;
  localparam int unsigned SW  = 8;   // small so saturation is reachable
  localparam int CMAX = (1 << CW) - 1;
  localparam int CWNT = (1 << (CW - 1)) - 1;
  localparam int CWT  = 1 << (CW - 1);
  localparam int SMAX = (1 << SW) - 1;

  logic          clk, rst;
  logic [31:0]   if_pc;
  logic          pred_hit, pred_taken;
  logic [31:0]   pred_target;
  logic          upd_valid, upd_taken, upd_is_jump, upd_pred_taken, inv_all;
  logic [31:0]   upd_pc, upd_target, upd_pred_target;
  logic          mispredict;
  logic [31:0]   redirect_pc;
  logic [SW-1:0] stat_updates, stat_mispred;

  branch_predictor_btb #(
    .XLEN(32), .ENTRIES(ENT), .CNT_W(CW), .STAT_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_is_jump(upd_is_jump),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .inv_all(inv_all), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_updates(stat_updates), .stat_mispred(stat_mispred)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: one record per table slot, plain integers for counters.
  bit          m_valid [ENT];
  int unsigned m_tag   [ENT];
  logic [31:0] m_tgt   [ENT];
  int          m_ctr   [ENT];
  bit          m_jump  [ENT];
  int          m_upd, m_mis;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = CWNT;
    end
    m_upd = 0;
    m_mis = 0;
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output bit hit, output bit tk,
                                   output logic [31:0] tgt);
    int i = int'((pc / 4) % ENT);
    hit = m_valid[i] && (m_tag[i] == pc / (4 * ENT));
    tk  = hit && (m_jump[i] || m_ctr[i] >= CWT);
    tgt = tk ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic void m_train(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                                  input bit jmp);
    int i = int'((pc / 4) % ENT);
    bit hit = m_valid[i] && (m_tag[i] == pc / (4 * ENT));
    if (hit && tk) begin
      m_tgt[i]  = tgt;
      m_jump[i] = jmp;
      m_ctr[i]  = jmp ? CMAX : ((m_ctr[i] + 1 > CMAX) ? CMAX : m_ctr[i] + 1);
    end else if (hit) begin
      m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
    end else if (tk) begin
      m_valid[i] = 1;
      m_tag[i]   = pc / (4 * ENT);
      m_tgt[i]   = tgt;
      m_jump[i]  = jmp;
      m_ctr[i]   = jmp ? CMAX : CWT;
    end
  endfunction

  task automatic look(input logic [31:0] pc, input bit e_hit, input bit e_tk,
                      input logic [31:0] e_tgt);
    if_pc = pc;
    #1;
    chk("dir_hit", 64'(pred_hit), 64'(e_hit));
    chk("dir_taken", 64'(pred_taken), 64'(e_tk));
    chk("dir_target", 64'(pred_target), 64'(e_tgt));
  endtask

  // One clock of traffic: check lookup and mispredict before the edge, stats after it.
  task automatic cycle(input logic [31:0] ipc, input bit uv, input logic [31:0] upc,
                       input bit ut, input logic [31:0] utgt, input bit uj, input bit upt,
                       input logic [31:0] uptgt, input bit inv);
    bit h, t, e_mp;
    logic [31:0] g;
    if_pc = ipc;  upd_valid = uv;  upd_pc = upc;  upd_taken = ut;
    upd_target = utgt;  upd_is_jump = uj;  upd_pred_taken = upt;
    upd_pred_target = uptgt;  inv_all = inv;
    #1;
    m_lookup(ipc, h, t, g);
    chk("lookup_hit", 64'(pred_hit), 64'(h));
    chk("lookup_taken", 64'(pred_taken), 64'(t));
    chk("lookup_target", 64'(pred_target), 64'(g));
    e_mp = uv && ((ut != upt) || (ut && utgt != uptgt));
    chk("mispredict", 64'(mispredict), 64'(e_mp));
    if (uv) chk("redirect_pc", 64'(redirect_pc), 64'(ut ? utgt : upc + 32'd4));
    @(posedge clk);
    #1;
    if (inv) m_reset_table();
    else if (uv) m_train(upc, ut, utgt, uj);
    if (uv && m_upd < SMAX) m_upd++;
    if (e_mp && m_mis < SMAX) m_mis++;
    upd_valid = 1'b0;
    inv_all   = 1'b0;
    chk("stat_updates", 64'(stat_updates), 64'(m_upd));
    chk("stat_mispred", 64'(stat_mispred), 64'(m_mis));
  endtask

  function automatic void m_reset_table();
    for (int i = 0; i < ENT; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = CWNT;
    end
  endfunction

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt, input bit jmp,
                     input bit ptk, input logic [31:0] ptgt);
    cycle(if_pc, 1'b1, pc, tk, tgt, jmp, ptk, ptgt, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    if_pc = 32'h100;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0; upd_is_jump = 0;
    upd_pred_taken = 0; upd_pred_target = 0; inv_all = 0;
    m_reset();
    #12;
    // Reset held: nothing predicted, stats cleared.
    look(32'h100, 0, 0, 32'h104);
    chk("rst_stat_updates", 64'(stat_updates), 64'd0);
    chk("rst_stat_mispred", 64'(stat_mispred), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // First taken branch: mispredicted, then allocated as weakly taken.
    cycle(32'h100, 1, 32'h100, 1, 32'h40, 0, 0, 32'h0, 0);
    look(32'h100, 1, 1, 32'h40);
    chk("first_mispred_count", 64'(stat_mispred), 64'd1);

    // Saturate at 3, then two not-taken drop it to 1 -> predicted not-taken.
    for (int k = 0; k < 3; k++) upd(32'h100, 1, 32'h40, 0, 1, 32'h40);
    look(32'h100, 1, 1, 32'h40);
    upd(32'h100, 0, 32'h0, 0, 1, 32'h40);
    look(32'h100, 1, 1, 32'h40);
    upd(32'h100, 0, 32'h0, 0, 1, 32'h40);
    look(32'h100, 1, 0, 32'h104);

    // Aliasing on index 0: 0x140 evicts 0x100; not-taken miss on 0x180 allocates nothing.
    upd(32'h100, 1, 32'h40, 0, 0, 32'h0);
    upd(32'h140, 1, 32'h500, 0, 0, 32'h0);
    look(32'h100, 0, 0, 32'h104);
    look(32'h140, 1, 1, 32'h500);
    upd(32'h180, 0, 32'h0, 0, 0, 32'h0);
    look(32'h180, 0, 0, 32'h184);
    look(32'h140, 1, 1, 32'h500);

    // JAL lands at MAX; one not-taken keeps it predicted taken.
    upd(32'h20, 1, 32'h300, 1, 0, 32'h0);
    look(32'h20, 1, 1, 32'h300);
    upd(32'h20, 0, 32'h0, 0, 1, 32'h300);
    look(32'h20, 1, 1, 32'h300);

    // PC+4 wraps at the top of the address space.
    look(32'hFFFF_FFFC, 0, 0, 32'h0);

    // inv_all beats a same-cycle update but stats still count it.
    cycle(32'h20, 1, 32'h100, 1, 32'h40, 0, 0, 32'h0, 1);
    look(32'h20, 0, 0, 32'h24);
    look(32'h140, 0, 0, 32'h144);
    look(32'h100, 0, 0, 32'h104);

    // No bypass: same-cycle lookup sees the pre-update miss (checked inside cycle).
    cycle(32'h100, 1, 32'h100, 1, 32'h80, 0, 0, 32'h0, 0);
    look(32'h100, 1, 1, 32'h80);

    // Random traffic over a small PC pool so hits, aliasing and saturation all occur.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ipc, upc, utgt, ptgt;
      bit uv, ut, uj, upt, inv, h, t;
      logic [31:0] g;
      ipc  = (($urandom % 4) << 6) | (($urandom % ENT) << 2) | ($urandom % 4);
      upc  = (($urandom % 4) << 6) | (($urandom % ENT) << 2) | ($urandom % 4);
      uv   = ($urandom % 4) != 0;
      uj   = ($urandom % 6) == 0;
      ut   = uj || ($urandom % 2);
      utgt = ($urandom % 8) << 4;
      inv  = ($urandom % 40) == 0;
      m_lookup(upc, h, t, g);
      if ($urandom % 3 != 0) begin
        upt = t;  ptgt = g;
      end else begin
        upt = $urandom % 2;  ptgt = ($urandom % 8) << 4;
      end
      cycle(ipc, uv, upc, ut, utgt, uj, upt, ptgt, inv);
    end
    chk("stat_updates_saturated", 64'(stat_updates), 64'(SMAX));

    // Asynchronous reset mid-run clears everything without a clock edge.
    upd(32'h100, 1, 32'h40, 0, 0, 32'h0);
    if_pc = 32'h100;
    #2;
    rst = 1'b0;
    m_reset();
    #1;
    chk("async_rst_updates", 64'(stat_updates), 64'd0);
    chk("async_rst_mispred", 64'(stat_mispred), 64'd0);
    chk("async_rst_hit", 64'(pred_hit), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    look(32'h100, 0, 0, 32'h104);
    for (int n = 0; n < 20; n++) begin
      logic [31:0] pc;
      pc = ($urandom % ENT) << 2;
      cycle(pc, 1, pc, 1, 32'h700, 0, 0, 32'h0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
